uart_port_arbiter: RTL and testbench
====================================

UART_PORT_ARBITER -- requirements
Module: uart_port_arbiter

Interface
REQ-001 Parameter: IDLE_TIMEOUT, default 1024; clk cycles of line inactivity before the active grant is released.
REQ-002 Parameter: NPORTS, fixed at 4; number of device UART ports sharing the host UART.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 host_rx  input  1  serial line from the host UART; idles high.
REQ-006 host_tx  output  1  serial line to the host UART; idles high.
REQ-007 dev_rx  input  4  serial lines from device ports 0-3; each idles high.
REQ-008 dev_tx  output  4  serial lines to device ports 0-3; each idles high.
REQ-009 force_en  input  1  manual override enable; uses the same role as the static select pins.
REQ-010 force_sel  input  2  port selected while force_en=1.
REQ-011 grant  output  2  index of the device port currently connected to the host.
REQ-012 grant_valid  output  1  1 while any port is connected.

Function
REQ-013 All asynchronous line inputs (host_rx, dev_rx, force_en, force_sel) SHALL pass through 2-flop synchronisers before use.
REQ-014 States SHALL be IDLE, AUTO and FORCED.
REQ-015 IDLE: host_tx=1, dev_tx=4'b1111, grant_valid=0, grant holds its last value.
REQ-016 IDLE->AUTO SHALL occur on a synchronised falling edge (previous 1, current 0) of any dev_rx.
REQ-017 Simultaneous falling edges SHALL be resolved round-robin: the first requesting port at or after (last_grant+1) mod 4 wins.
REQ-018 In AUTO/FORCED, routing SHALL be registered: host_tx <= sync dev_rx[grant], dev_tx[grant] <= sync host_rx, and every other dev_tx bit = 1.
REQ-019 Line-to-line latency SHALL be exactly 3 cycles: 2 synchroniser cycles plus 1 output-register cycle.
REQ-020 Because of this latency, the start bit that triggers a grant SHALL reach host_tx intact.
REQ-021 Idle counter behaviour in AUTO: counts cycles in which both sync dev_rx[grant] and sync host_rx are 1; clears on any 0 on either line.
REQ-022 The idle counter SHALL saturate at IDLE_TIMEOUT and be ceil(log2(IDLE_TIMEOUT+1)) bits wide.
REQ-023 AUTO->IDLE SHALL occur in the cycle after the counter reaches IDLE_TIMEOUT.
REQ-024 On that release, last_grant SHALL be updated to grant.
REQ-025 A falling edge on a non-granted dev_rx while in AUTO SHALL be ignored; it is not queued.
REQ-026 Sync force_en=1 in any state SHALL go to FORCED with grant=force_sel on the next cycle.
REQ-027 In FORCED, grant SHALL track force_sel changes with 1-cycle latency, and the timeout SHALL be disabled.
REQ-028 Sync force_en 1->0 SHALL go to IDLE, with the idle counter cleared and last_grant unchanged.
REQ-029 grant and grant_valid SHALL be registered and change on the same edge as the state.

Reset
REQ-030 While rst=1 the block SHALL hold: state=IDLE, host_tx=1, dev_tx=4'b1111, grant=0, grant_valid=0, last_grant=3, idle counter=0, synchroniser flops=1.
REQ-031 Reset asserted mid-frame SHALL force the lines idle on the next edge.
REQ-032 After reset, a truncated frame SHALL NOT be resumed.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, AUTO, FORCED), the NPORTS constant and the port-index type.
REQ-034 One sub-module, uart_line_sync, SHALL implement the 2-flop synchroniser with registered falling-edge detect.
REQ-035 uart_line_sync SHALL be instantiated once per serial input (5 instances).

Verification
REQ-036 Scenario 1: dev_rx[2] falls at cycle 10 -> grant=2 and grant_valid=1 at cycle 13; host_tx low from cycle 13; dev_tx[2] mirrors host_rx with 3-cycle delay.
REQ-037 Scenario 2: dev_rx[0] and dev_rx[3] fall on the same cycle after reset -> port 0 granted; after its timeout release, the next simultaneous fall of ports 0 and 3 -> port 3 granted.
REQ-038 Scenario 3: IDLE_TIMEOUT=16, granted port sends a 0x55 frame, then lines stay high -> grant_valid drops exactly 17 cycles after the last synchronised low.
REQ-039 Scenario 4: dev_rx[1] falls while port 2 is granted -> grant stays 2 and port 1 is never granted from that edge.
REQ-040 Scenario 5: force_en=1, force_sel=3 during AUTO on port 1 -> FORCED with grant=3; force_sel->0 -> grant=0 one cycle later; no timeout after 2000 idle cycles; force_en=0 -> IDLE.
REQ-041 Scenario 6: rst pulse mid-frame on port 1 -> next edge host_tx=1, dev_tx=4'b1111, grant_valid=0; the next request is arbitrated from port 0.

Source files
------------

// File: rtl/uart_port_arbiter_pkg.sv
// Shared types and constants for the host/device UART port arbiter.
// Holds the arbiter state encoding, port count and round-robin picker.
package uart_port_arbiter_pkg;

  localparam int unsigned NPORTS = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAuto   = 2'd1,
    StForced = 2'd2
  } arb_state_t;

  // First requester at or after (last + 1) mod NPORTS.
  function automatic port_idx_t rr_pick(input logic [NPORTS-1:0] req, input port_idx_t last);
    port_idx_t idx;
    port_idx_t pick;
    logic      found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      idx = port_idx_t'(last + i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_line_sync.sv
// Two-flop synchroniser for an idle-high serial line, with a registered
// falling-edge flag aligned to the cycle in which the synchronised value first reads 0.
module uart_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      fall <= sync & ~meta;
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Connects one host UART to one of four device UARTs, granting on the first
// start bit seen, releasing after a period of line inactivity, with a manual override.
module uart_port_arbiter
  import uart_port_arbiter_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_rx,
  output logic              host_tx,
  input  logic [NPORTS-1:0] dev_rx,
  output logic [NPORTS-1:0] dev_tx,
  input  logic              force_en,
  input  logic [1:0]        force_sel,
  output logic [1:0]        grant,
  output logic              grant_valid
);

  localparam int unsigned CntW = $clog2(IDLE_TIMEOUT + 1);

  logic              host_sync;
  logic              unused_host_fall;
  logic [NPORTS-1:0] dev_sync;
  logic [NPORTS-1:0] dev_fall;

  uart_line_sync u_host_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (host_rx),
    .sync (host_sync),
    .fall (unused_host_fall)
  );

  for (genvar i = 0; i < NPORTS; i++) begin : g_dev_sync
    uart_line_sync u_dev_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (dev_rx[i]),
      .sync (dev_sync[i]),
      .fall (dev_fall[i])
    );
  end

  // Override controls are level signals, so a plain two-flop stage suffices.
  logic [2:0] force_meta;
  logic [2:0] force_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      force_meta <= '0;
      force_sync <= '0;
    end else begin
      force_meta <= {force_en, force_sel};
      force_sync <= force_meta;
    end
  end

  logic      force_en_s;
  port_idx_t force_sel_s;
  assign force_en_s  = force_sync[2];
  assign force_sel_s = force_sync[1:0];

  arb_state_t        state_q, state_d;
  port_idx_t         grant_q, grant_d;
  port_idx_t         last_grant_q, last_grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              grant_valid_q, grant_valid_d;
  logic              host_tx_q, host_tx_d;
  logic [NPORTS-1:0] dev_tx_q, dev_tx_d;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (force_en_s) begin
          state_d = StForced;
          grant_d = force_sel_s;
        end else if (|dev_fall) begin
          state_d = StAuto;
          grant_d = rr_pick(dev_fall, last_grant_q);
        end
      end
      StAuto: begin
        if (force_en_s) begin
          state_d = StForced;
          grant_d = force_sel_s;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(IDLE_TIMEOUT)) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
          cnt_d        = '0;
        end else if (dev_sync[grant_q] && host_sync) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      StForced: begin
        cnt_d = '0;
        if (!force_en_s) begin
          state_d = StIdle;
        end else begin
          grant_d = force_sel_s;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Routing follows the next grant so the triggering start bit is forwarded.
    grant_valid_d = (state_d != StIdle);
    host_tx_d     = 1'b1;
    dev_tx_d      = '1;
    if (grant_valid_d) begin
      host_tx_d         = dev_sync[grant_d];
      dev_tx_d[grant_d] = host_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_grant_q  <= port_idx_t'(NPORTS - 1);
      cnt_q         <= '0;
      grant_valid_q <= 1'b0;
      host_tx_q     <= 1'b1;
      dev_tx_q      <= '1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      grant_valid_q <= grant_valid_d;
      host_tx_q     <= host_tx_d;
      dev_tx_q      <= dev_tx_d;
    end
  end

  assign host_tx     = host_tx_q;
  assign dev_tx      = dev_tx_q;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Self-checking bench for uart_port_arbiter: line routing via an expected-value
// queue, arbitration, timeout release, override and mid-frame reset.
module tb_uart_port_arbiter;

  localparam int unsigned Timeout = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_rx;
  logic       host_tx;
  logic [3:0] dev_rx;
  logic [3:0] dev_tx;
  logic       force_en;
  logic [1:0] force_sel;
  logic [1:0] grant;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic       htx;
    logic [3:0] dtx;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  uart_port_arbiter #(
    .IDLE_TIMEOUT (Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_rx     (host_rx),
    .host_tx     (host_tx),
    .dev_rx      (dev_rx),
    .dev_tx      (dev_tx),
    .force_en    (force_en),
    .force_sel   (force_sel),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    host_rx   = 1'b1;
    dev_rx    = 4'b1111;
    force_en  = 1'b0;
    force_sel = 2'd0;
    sb.delete();
    repeat (3) tick();
    checks++;
    if ({host_tx, dev_tx, grant_valid, grant} !== {1'b1, 4'b1111, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got htx=%b dtx=%b gv=%b g=%0d, want htx=1 dtx=1111 gv=0 g=0",
               host_tx, dev_tx, grant_valid, grant);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  // Grant on port 2, 0x55 frame forwarded, intruder on port 1 ignored, timed release.
  task automatic test_frame_route();
    logic [9:0] frame;
    logic [7:0] hpat;
    logic       d;
    logic       h;
    logic [3:0] dexp;
    exp_t       e;
    int         last_low;
    int         rel_cyc;
    logic       seen_valid;
    logic       bad_grant;
    frame      = {1'b1, 8'h55, 1'b0};
    hpat       = 8'b0011_0101;
    last_low   = -1;
    rel_cyc    = -1;
    seen_valid = 1'b0;
    bad_grant  = 1'b0;
    while (cyc < 10) tick();
    for (int n = 0; n < 80; n++) begin
      d = (n < 40) ? frame[n/4] : 1'b1;
      h = (n < 8) ? hpat[n] : 1'b1;
      dev_rx    = 4'b1111;
      dev_rx[2] = d;
      if (n >= 12) dev_rx[1] = 1'b0;
      host_rx = h;
      dexp    = 4'b1111;
      dexp[2] = h;
      sb.push_back('{due: cyc + 3, htx: d, dtx: dexp});
      tick();
      if (cyc == 12) begin
        checks++;
        if (grant_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_grant: cycle 12 grant_valid=%b, want 0", grant_valid);
        end
      end
      if (cyc == 13) begin
        checks++;
        if ({grant_valid, grant} !== {1'b1, 2'd2}) begin
          errors++;
          $display("FAIL grant_at_13: got gv=%b g=%0d, want gv=1 g=2", grant_valid, grant);
        end
      end
      while (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({host_tx, dev_tx} !== {e.htx, e.dtx}) begin
          errors++;
          $display("FAIL route_c%0d: got htx=%b dtx=%b, want htx=%b dtx=%b",
                   cyc, host_tx, dev_tx, e.htx, e.dtx);
        end
      end
      if (host_tx === 1'b0) last_low = cyc;
      if (grant_valid === 1'b1) begin
        seen_valid = 1'b1;
        if (grant !== 2'd2) bad_grant = 1'b1;
      end
      if (seen_valid && grant_valid === 1'b0 && rel_cyc < 0) rel_cyc = cyc;
    end
    checks++;
    if (bad_grant) begin
      errors++;
      $display("FAIL grant_hold: grant left port 2 while valid, want 2 throughout");
    end
    checks++;
    if (rel_cyc < 0 || (rel_cyc - last_low) != 17) begin
      errors++;
      $display("FAIL timeout_release: release %0d cycles after last host_tx low (rel=%0d), want 17",
               rel_cyc - last_low, rel_cyc);
    end
    checks++;
    if ({grant_valid, grant} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL intruder_ignored: got gv=%b g=%0d, want gv=0 g=2", grant_valid, grant);
    end
    dev_rx = 4'b1111;
    repeat (5) tick();
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (grant_valid !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: grant_valid=%b after 200 cycles, want 0", name, grant_valid);
    end
  endtask

  task automatic test_round_robin();
    dev_rx = 4'b0110;
    repeat (3) tick();
    checks++;
    if ({grant_valid, grant} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL rr_first: got gv=%b g=%0d, want gv=1 g=0", grant_valid, grant);
    end
    repeat (2) tick();
    dev_rx = 4'b1111;
    wait_release("rr_release1");
    repeat (2) tick();
    dev_rx = 4'b0110;
    repeat (3) tick();
    checks++;
    if ({grant_valid, grant} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL rr_second: got gv=%b g=%0d, want gv=1 g=3", grant_valid, grant);
    end
    repeat (2) tick();
    dev_rx = 4'b1111;
    wait_release("rr_release2");
  endtask

  task automatic test_force();
    logic dropped;
    dropped = 1'b0;
    dev_rx  = 4'b1101;
    repeat (3) tick();
    checks++;
    if ({grant_valid, grant} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL force_auto_p1: got gv=%b g=%0d, want gv=1 g=1", grant_valid, grant);
    end
    dev_rx    = 4'b0111;
    force_en  = 1'b1;
    force_sel = 2'd3;
    repeat (3) tick();
    checks++;
    if ({grant_valid, grant, host_tx} !== {1'b1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL force_sel3: got gv=%b g=%0d htx=%b, want gv=1 g=3 htx=0",
               grant_valid, grant, host_tx);
    end
    dev_rx    = 4'b1111;
    force_sel = 2'd0;
    repeat (2) tick();
    checks++;
    if (grant !== 2'd3) begin
      errors++;
      $display("FAIL force_sel_early: got g=%0d, want 3", grant);
    end
    tick();
    checks++;
    if (grant !== 2'd0) begin
      errors++;
      $display("FAIL force_sel0: got g=%0d, want 0", grant);
    end
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (grant_valid !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL force_no_timeout: grant_valid dropped during 2000 idle cycles, want 1");
    end
    force_en = 1'b0;
    repeat (3) tick();
    checks++;
    if ({grant_valid, host_tx, dev_tx} !== {1'b0, 1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL force_exit: got gv=%b htx=%b dtx=%b, want gv=0 htx=1 dtx=1111",
               grant_valid, host_tx, dev_tx);
    end
  endtask

  task automatic test_reset_midframe();
    dev_rx = 4'b1101;
    repeat (3) tick();
    checks++;
    if ({grant_valid, grant} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL mid_grant_p1: got gv=%b g=%0d, want gv=1 g=1", grant_valid, grant);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({host_tx, dev_tx, grant_valid, grant} !== {1'b1, 4'b1111, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset_lines: got htx=%b dtx=%b gv=%b g=%0d, want htx=1 dtx=1111 gv=0 g=0",
               host_tx, dev_tx, grant_valid, grant);
    end
    dev_rx = 4'b1111;
    tick();
    rst = 1'b0;
    cyc = 0;
    repeat (10) tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_resume: got gv=%b, want 0", grant_valid);
    end
    dev_rx = 4'b1010;
    repeat (3) tick();
    checks++;
    if ({grant_valid, grant} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL post_reset_rr: got gv=%b g=%0d, want gv=1 g=0", grant_valid, grant);
    end
    dev_rx = 4'b1111;
    wait_release("post_reset_release");
  endtask

  initial begin
    test_reset();
    test_frame_route();
    test_reset();
    test_round_robin();
    test_force();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
